// File: rtl/stim_pkg.sv
// Shared types for the stimulus pulse decoder: FSM state, error-bit indices
// and the {cat, ano, dis} phase pattern.
package stim_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEAD,
        S_CAT,
        S_IPD,
        S_ANO,
        S_DDLY,
        S_DIS,
        S_TAIL,
        S_FAULT
    } stim_state_t;

    localparam int ERR_W        = 5;
    localparam int ERR_OVERLAP  = 0;
    localparam int ERR_ORDER    = 1;
    localparam int ERR_ABORT    = 2;
    localparam int ERR_IMBAL    = 3;
    localparam int ERR_FIELDCHG = 4;

    typedef struct packed {
        logic cat;
        logic ano;
        logic dis;
    } phase_t;

    function automatic logic multi_hot(input phase_t p);
        return (p.cat & p.ano) | (p.cat & p.dis) | (p.ano & p.dis);
    endfunction

endpackage

// File: rtl/stim_pulse_decoder_if.sv
// Stimulus control bus plus the per-pulse report returned by the decoder.
interface stim_pulse_decoder_if #(
    parameter int CNT_W = 16,
    parameter int MAG_W = 5,
    parameter int CH_W  = 2
);
    // Handshake: no back-pressure; pulse_valid is a one-cycle strobe and the
    // report fields are valid with it and hold until the next strobe.
    logic             en;
    logic             cat;
    logic             ano;
    logic             dis;
    logic [CH_W-1:0]  ch_sel_u;
    logic [CH_W-1:0]  ch_sel_d;
    logic [MAG_W-1:0] mag;
    logic             err_clr;

    logic             pulse_valid;
    logic [CNT_W-1:0] cat_len;
    logic [CNT_W-1:0] ipd_len;
    logic [CNT_W-1:0] ano_len;
    logic [CNT_W-1:0] dis_len;
    logic [MAG_W-1:0] pulse_mag;
    logic [CH_W-1:0]  pulse_ch_u;
    logic [CH_W-1:0]  pulse_ch_d;
    logic [4:0]       pulse_err;
    logic [4:0]       err_sticky;
    logic [15:0]      pulse_cnt;
    stim_pkg::stim_state_t state;

    modport master (
        output en, cat, ano, dis, ch_sel_u, ch_sel_d, mag, err_clr,
        input  pulse_valid, cat_len, ipd_len, ano_len, dis_len, pulse_mag,
               pulse_ch_u, pulse_ch_d, pulse_err, err_sticky, pulse_cnt, state
    );

    modport slave (
        input  en, cat, ano, dis, ch_sel_u, ch_sel_d, mag, err_clr,
        output pulse_valid, cat_len, ipd_len, ano_len, dis_len, pulse_mag,
               pulse_ch_u, pulse_ch_d, pulse_err, err_sticky, pulse_cnt, state
    );

endinterface

// File: rtl/stim_sat_counter.sv
// Phase-length counter: synchronous clear, count enable, sticks at all-ones.
module stim_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/stim_pulse_decoder.sv
// Biphasic pulse receiver: follows the phase sequence, measures each phase and
// emits a one-cycle report with an error bitmask at the end of every pulse.
module stim_pulse_decoder
    import stim_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int MAG_W   = 5,
    parameter int CH_W    = 2,
    parameter int BAL_TOL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stim_pulse_decoder_if.slave  bus
);

    logic             en_q, err_clr_q;
    phase_t           ph_q;
    logic [CH_W-1:0]  ch_u_q, ch_d_q, cap_ch_u, cap_ch_d;
    logic [MAG_W-1:0] mag_q, cap_mag;

    stim_state_t      state, state_next;
    logic             multi, any_ph;
    logic             start, report, abort, imbal, idle_act;
    logic             cat_en, ipd_en, ano_en, dis_en;
    logic [ERR_W-1:0] set_bits, err_acc, report_err;
    logic [CNT_W-1:0] cat_cnt, ipd_cnt, ano_cnt, dis_cnt, diff;

    logic             pulse_valid_r;
    logic [CNT_W-1:0] cat_len_r, ipd_len_r, ano_len_r, dis_len_r;
    logic [MAG_W-1:0] pulse_mag_r;
    logic [CH_W-1:0]  pulse_ch_u_r, pulse_ch_d_r;
    logic [ERR_W-1:0] pulse_err_r, err_sticky_r;
    logic [15:0]      pulse_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            ph_q      <= '0;
            ch_u_q    <= '0;
            ch_d_q    <= '0;
            mag_q     <= '0;
            err_clr_q <= 1'b0;
        end else begin
            en_q      <= bus.en;
            ph_q      <= '{cat: bus.cat, ano: bus.ano, dis: bus.dis};
            ch_u_q    <= bus.ch_sel_u;
            ch_d_q    <= bus.ch_sel_d;
            mag_q     <= bus.mag;
            err_clr_q <= bus.err_clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    assign multi  = multi_hot(ph_q);
    assign any_ph = ph_q.cat | ph_q.ano | ph_q.dis;

    // en_q low outranks overlap, which outranks the normal phase transitions.
    always_comb begin
        state_next = state;
        if (state == S_IDLE) begin
            if (en_q) state_next = S_LEAD;
        end else if (!en_q) begin
            state_next = S_IDLE;
        end else if (multi) begin
            state_next = S_FAULT;
        end else begin
            case (state)
                S_LEAD: if (ph_q.cat) state_next = S_CAT;
                        else if (any_ph) state_next = S_FAULT;
                S_CAT:  if (!any_ph) state_next = S_IPD;
                        else if (ph_q.ano) state_next = S_ANO;
                        else if (ph_q.dis) state_next = S_FAULT;
                S_IPD:  if (ph_q.ano) state_next = S_ANO;
                        else if (any_ph) state_next = S_FAULT;
                S_ANO:  if (!any_ph) state_next = S_DDLY;
                        else if (ph_q.dis) state_next = S_DIS;
                        else if (ph_q.cat) state_next = S_FAULT;
                S_DDLY: if (ph_q.dis) state_next = S_DIS;
                        else if (any_ph) state_next = S_FAULT;
                S_DIS:  if (!any_ph) state_next = S_TAIL;
                        else if (ph_q.cat || ph_q.ano) state_next = S_FAULT;
                S_TAIL: if (any_ph) state_next = S_FAULT;
                default: state_next = state;
            endcase
        end
    end

    // Counters key off the next state so the entry cycle of a phase counts as 1.
    always_comb begin
        start    = (state == S_IDLE) && en_q;
        report   = (state != S_IDLE) && !en_q;
        abort    = report && (state != S_TAIL) && (state != S_FAULT);
        idle_act = (state == S_IDLE) && any_ph;
        cat_en   = (state_next == S_CAT) && ph_q.cat;
        ipd_en   = (state_next == S_IPD);
        ano_en   = (state_next == S_ANO);
        dis_en   = (state_next == S_DIS);
        set_bits = '0;
        set_bits[ERR_OVERLAP]  = (state != S_IDLE) && en_q && multi;
        set_bits[ERR_ORDER]    = (state != S_IDLE) && (state != S_FAULT) && en_q &&
                                 !multi && (state_next == S_FAULT);
        set_bits[ERR_FIELDCHG] = (state != S_IDLE) && en_q &&
                                 ((mag_q != cap_mag) || (ch_u_q != cap_ch_u) ||
                                  (ch_d_q != cap_ch_d));
    end

    always_comb begin
        diff  = (cat_cnt >= ano_cnt) ? (cat_cnt - ano_cnt) : (ano_cnt - cat_cnt);
        imbal = diff > CNT_W'(BAL_TOL);
        report_err = err_acc;
        report_err[ERR_ABORT] = err_acc[ERR_ABORT] | abort;
        report_err[ERR_IMBAL] = err_acc[ERR_IMBAL] | imbal;
    end

    stim_sat_counter #(.W(CNT_W)) u_cat_cnt (.clk(clk), .rst_n(rst_n), .clr(start), .en(cat_en), .count(cat_cnt));
    stim_sat_counter #(.W(CNT_W)) u_ipd_cnt (.clk(clk), .rst_n(rst_n), .clr(start), .en(ipd_en), .count(ipd_cnt));
    stim_sat_counter #(.W(CNT_W)) u_ano_cnt (.clk(clk), .rst_n(rst_n), .clr(start), .en(ano_en), .count(ano_cnt));
    stim_sat_counter #(.W(CNT_W)) u_dis_cnt (.clk(clk), .rst_n(rst_n), .clr(start), .en(dis_en), .count(dis_cnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_mag  <= '0;
            cap_ch_u <= '0;
            cap_ch_d <= '0;
            err_acc  <= '0;
        end else if (start) begin
            cap_mag  <= mag_q;
            cap_ch_u <= ch_u_q;
            cap_ch_d <= ch_d_q;
            err_acc  <= '0;
        end else begin
            err_acc  <= err_acc | set_bits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_valid_r <= 1'b0;
            cat_len_r     <= '0;
            ipd_len_r     <= '0;
            ano_len_r     <= '0;
            dis_len_r     <= '0;
            pulse_mag_r   <= '0;
            pulse_ch_u_r  <= '0;
            pulse_ch_d_r  <= '0;
            pulse_err_r   <= '0;
            pulse_cnt_r   <= '0;
            err_sticky_r  <= '0;
        end else begin
            pulse_valid_r <= report;
            if (report) begin
                cat_len_r    <= cat_cnt;
                ipd_len_r    <= ipd_cnt;
                ano_len_r    <= ano_cnt;
                dis_len_r    <= dis_cnt;
                pulse_mag_r  <= cap_mag;
                pulse_ch_u_r <= cap_ch_u;
                pulse_ch_d_r <= cap_ch_d;
                pulse_err_r  <= report_err;
                pulse_cnt_r  <= pulse_cnt_r + 16'd1;
            end
            // A clear loses to bits arriving in the same cycle.
            err_sticky_r <= (err_clr_q ? '0 : err_sticky_r) |
                            (report ? report_err : '0) |
                            (idle_act ? ERR_W'(1 << ERR_ORDER) : '0);
        end
    end

    assign bus.pulse_valid = pulse_valid_r;
    assign bus.cat_len     = cat_len_r;
    assign bus.ipd_len     = ipd_len_r;
    assign bus.ano_len     = ano_len_r;
    assign bus.dis_len     = dis_len_r;
    assign bus.pulse_mag   = pulse_mag_r;
    assign bus.pulse_ch_u  = pulse_ch_u_r;
    assign bus.pulse_ch_d  = pulse_ch_d_r;
    assign bus.pulse_err   = pulse_err_r;
    assign bus.err_sticky  = err_sticky_r;
    assign bus.pulse_cnt   = pulse_cnt_r;
    assign bus.state       = state;

endmodule

// File: tb/tb_stim_pulse_decoder.sv
// Directed bench for stim_pulse_decoder: phase sequences with hand-computed
// reports, error cases, counter saturation, pulse-count wrap and mid-pulse reset.
`timescale 1ns/1ps
module tb_stim_pulse_decoder;
    import stim_pkg::*;

    // Narrow counters keep the saturation case short (all-ones = 0xFFF).
    localparam int CNT_W = 12;
    localparam int MAG_W = 5;
    localparam int CH_W  = 2;
    localparam int REP_W = 5 + 4 * CNT_W + MAG_W + 2 * CH_W;

    typedef struct packed {
        logic [4:0]       err;
        logic [CNT_W-1:0] cat;
        logic [CNT_W-1:0] ipd;
        logic [CNT_W-1:0] ano;
        logic [CNT_W-1:0] dis;
        logic [MAG_W-1:0] mag;
        logic [CH_W-1:0]  chu;
        logic [CH_W-1:0]  chd;
    } rep_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #500 clk = ~clk;

    stim_pulse_decoder_if #(.CNT_W(CNT_W), .MAG_W(MAG_W), .CH_W(CH_W)) bus ();

    stim_pulse_decoder #(
        .CNT_W(CNT_W), .MAG_W(MAG_W), .CH_W(CH_W), .BAL_TOL(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int strobes  = 0;
    int exp_cnt  = 0;
    logic [REP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every strobe is matched against the oldest expected report
    always @(negedge clk) begin : mon
        rep_t e;
        if (bus.pulse_valid) begin
            strobes++;
            check("report_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = rep_t'(exp_q.pop_front());
                check("pulse_err", 32'(bus.pulse_err), 32'(e.err));
                check("cat_len",   32'(bus.cat_len),   32'(e.cat));
                check("ipd_len",   32'(bus.ipd_len),   32'(e.ipd));
                check("ano_len",   32'(bus.ano_len),   32'(e.ano));
                check("dis_len",   32'(bus.dis_len),   32'(e.dis));
                check("pulse_mag", 32'(bus.pulse_mag), 32'(e.mag));
                check("pulse_ch_u", 32'(bus.pulse_ch_u), 32'(e.chu));
                check("pulse_ch_d", 32'(bus.pulse_ch_d), 32'(e.chd));
            end
        end
    end

    // driver tasks: inputs change on the falling edge
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic phase(input int n, input logic e, input logic c, input logic a, input logic d);
        bus.en  = e;
        bus.cat = c;
        bus.ano = a;
        bus.dis = d;
        hold(n);
    endtask

    task automatic push_exp(input logic [4:0] err, input int c, input int i, input int a,
                            input int d, input int m, input int u, input int dd);
        rep_t e;
        e.err = err;
        e.cat = CNT_W'(c);
        e.ipd = CNT_W'(i);
        e.ano = CNT_W'(a);
        e.dis = CNT_W'(d);
        e.mag = MAG_W'(m);
        e.chu = CH_W'(u);
        e.chd = CH_W'(dd);
        exp_q.push_back(REP_W'(e));
    endtask

    task automatic finish_pulse(input string tag);
        phase(4, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt++;
        check(tag, 32'(bus.pulse_cnt), 32'(exp_cnt[15:0]));
    endtask

    task automatic full_pulse(input int c, input int i, input int a, input int d);
        phase(10, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(c,  1'b1, 1'b1, 1'b0, 1'b0);
        if (i > 0) phase(i, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(a,  1'b1, 1'b0, 1'b1, 1'b0);
        phase(1,  1'b1, 1'b0, 1'b0, 1'b0);
        phase(d,  1'b1, 1'b0, 1'b0, 1'b1);
        phase(10, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int strobes_before;
        bus.en = 1'b0; bus.cat = 1'b0; bus.ano = 1'b0; bus.dis = 1'b0;
        bus.mag = 5'd9; bus.ch_sel_u = 2'd2; bus.ch_sel_d = 2'd1; bus.err_clr = 1'b0;
        hold(3);
        check("rst_valid",  32'(bus.pulse_valid), 32'd0);
        check("rst_cnt",    32'(bus.pulse_cnt),   32'd0);
        check("rst_sticky", 32'(bus.err_sticky),  32'd0);
        check("rst_cat",    32'(bus.cat_len),     32'd0);
        check("rst_state",  32'(bus.state),       32'(S_IDLE));
        rst_n = 1'b1;
        hold(2);

        // nominal pulse with explicit latency and strobe-width checks
        phase(10, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(75, 1'b1, 1'b1, 1'b0, 1'b0);
        check("state_cat", 32'(bus.state), 32'(S_CAT));
        phase(75, 1'b1, 1'b1, 1'b0, 1'b0);
        phase(10, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(150, 1'b1, 1'b0, 1'b1, 1'b0);
        phase(1, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(5, 1'b1, 1'b0, 1'b0, 1'b1);
        phase(10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("state_tail", 32'(bus.state), 32'(S_TAIL));
        push_exp(5'h00, 150, 10, 150, 5, 9, 2, 1);
        phase(1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("latency_1", 32'(bus.pulse_valid), 32'd0);
        hold(1);
        check("latency_2", 32'(bus.pulse_valid), 32'd1);
        hold(1);
        check("strobe_width", 32'(bus.pulse_valid), 32'd0);
        hold(1);
        exp_cnt++;
        check("cnt_nominal", 32'(bus.pulse_cnt), 32'(exp_cnt));

        // imbalance: diff 3 flags, diff 2 does not
        full_pulse(150, 10, 147, 5);
        push_exp(5'h08, 150, 10, 147, 5, 9, 2, 1);
        finish_pulse("cnt_imbal");
        full_pulse(150, 10, 148, 5);
        push_exp(5'h00, 150, 10, 148, 5, 9, 2, 1);
        finish_pulse("cnt_bal");

        // no inter-phase gap
        full_pulse(20, 0, 20, 3);
        push_exp(5'h00, 20, 0, 20, 3, 9, 2, 1);
        finish_pulse("cnt_noipd");

        // order: anodic before cathodic, FAULT held until en falls
        phase(5, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(5, 1'b1, 1'b0, 1'b1, 1'b0);
        check("state_fault_a", 32'(bus.state), 32'(S_FAULT));
        phase(5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("state_fault_b", 32'(bus.state), 32'(S_FAULT));
        push_exp(5'h02, 0, 0, 0, 0, 9, 2, 1);
        finish_pulse("cnt_order");

        // overlap: cat and dis together
        phase(5, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(3, 1'b1, 1'b1, 1'b0, 1'b1);
        push_exp(5'h01, 0, 0, 0, 0, 9, 2, 1);
        finish_pulse("cnt_overlap");

        // abort during the anodic phase: partial lengths, also unbalanced
        phase(10, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(150, 1'b1, 1'b1, 1'b0, 1'b0);
        phase(10, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(40, 1'b1, 1'b0, 1'b1, 1'b0);
        push_exp(5'h0C, 150, 10, 40, 0, 9, 2, 1);
        finish_pulse("cnt_abort");

        // field change: magnitude 9 -> 10 mid cathodic phase
        phase(10, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(20, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.mag = 5'd10;
        phase(20, 1'b1, 1'b1, 1'b0, 1'b0);
        phase(5, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(40, 1'b1, 1'b0, 1'b1, 1'b0);
        phase(1, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(4, 1'b1, 1'b0, 1'b0, 1'b1);
        phase(3, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(5'h10, 40, 5, 40, 4, 9, 2, 1);
        finish_pulse("cnt_fieldchg");
        bus.mag = 5'd9;

        // sticky accumulation, clear, then idle phase activity
        check("sticky_all", 32'(bus.err_sticky), 32'h1F);
        bus.err_clr = 1'b1;
        hold(1);
        bus.err_clr = 1'b0;
        hold(2);
        check("sticky_clr", 32'(bus.err_sticky), 32'h00);
        phase(3, 1'b0, 1'b1, 1'b0, 1'b0);
        phase(3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sticky_idle", 32'(bus.err_sticky), 32'h02);

        // cathodic phase longer than the counter range
        phase(2, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(4200, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(5'h0C, 4095, 0, 0, 0, 9, 2, 1);
        finish_pulse("cnt_sat");
        check("sticky_sat", 32'(bus.err_sticky), 32'h0E);

        // reset mid cathodic phase discards the pulse
        phase(3, 1'b1, 1'b0, 1'b0, 1'b0);
        phase(20, 1'b1, 1'b1, 1'b0, 1'b0);
        strobes_before = strobes;
        rst_n = 1'b0;
        phase(2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mrst_valid",  32'(bus.pulse_valid), 32'd0);
        check("mrst_cnt",    32'(bus.pulse_cnt),   32'd0);
        check("mrst_sticky", 32'(bus.err_sticky),  32'd0);
        check("mrst_cat",    32'(bus.cat_len),     32'd0);
        check("mrst_err",    32'(bus.pulse_err),   32'd0);
        check("mrst_mag",    32'(bus.pulse_mag),   32'd0);
        check("mrst_state",  32'(bus.state),       32'(S_IDLE));
        rst_n = 1'b1;
        hold(5);
        check("mrst_no_report", 32'(strobes), 32'(strobes_before));
        exp_cnt = 0;

        // 65536 minimal (aborted) pulses wrap the pulse counter to zero
        strobes_before = strobes;
        for (int i = 0; i < 65536; i++) begin
            push_exp(5'h04, 0, 0, 0, 0, 9, 2, 1);
            phase(1, 1'b1, 1'b0, 1'b0, 1'b0);
            phase(1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        hold(4);
        check("cnt_wrap", 32'(bus.pulse_cnt), 32'd0);
        check("wrap_strobes", 32'(strobes - strobes_before), 32'd65536);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
